// File: rtl/sp_ram_pkg.sv
// Shared constants for the sp_ram_param storage primitive: read-during-write
// mode codes, fill FSM state encodings and a byte-parity helper.
package sp_ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Even parity: the stored bit makes the 9-bit group an even count of ones.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sp_ram_fill_fsm.sv
// Post-reset zero-fill sequencer for sp_ram_param: walks every word once,
// raising busy and a fill write strobe, then parks in RUN.
module sp_ram_fill_fsm
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr
);

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FILL;
      ptr   <= '0;
    end else if (state == ST_FILL) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) state <= ST_RUN;
    end
  end

  // rst is folded in so busy is high throughout reset, not one edge later.
  assign busy      = rst | (state == ST_FILL);
  assign fill_we   = ~rst & (state == ST_FILL);
  assign fill_addr = ptr;

endmodule

// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, 1/2-cycle read
// latency, selectable read-during-write mode and zero-fill after reset.
// Optional per-lane even parity with error flag: define SP_RAM_PARITY_EN.
module sp_ram_param
  import sp_ram_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                busy,
  output logic                perr
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sp_ram_param: RD_LATENCY must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("sp_ram_param: DATA_W must be a multiple of 8");
  end

  logic              fill_we;
  logic [ADDR_W-1:0] fill_addr;

  sp_ram_fill_fsm #(.ADDR_W(ADDR_W)) u_fill (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .fill_we  (fill_we),
    .fill_addr(fill_addr)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_word, merged, rd_word;
  logic              wr, rd, rd_ok, wfirst;

  assign wr     = ~busy & we;
  assign rd     = ~busy & re;
  assign wfirst = wr && (RDW_MODE == RDW_WRITE_FIRST);
  assign rd_ok  = rd && !(wr && (RDW_MODE == RDW_NO_CHANGE));

  always_comb begin
    old_word = mem[addr];
    merged   = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
    rd_word = wfirst ? merged : old_word;
  end

  always_ff @(posedge clk) begin
    if (fill_we)  mem[fill_addr] <= '0;
    else if (wr)  mem[addr]      <= merged;
  end

  logic [DATA_W-1:0] q1;
  logic              v1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) q1 <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] q2;
    logic              v2;
    always_ff @(posedge clk) begin
      if (rst) begin
        q2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) q2 <= q1;
      end
    end
    assign q       = q2;
    assign q_valid = v2;
  end else begin : g_lat1
    assign q       = q1;
    assign q_valid = v1;
  end

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] merged_par, rd_par;
  logic          rd_err, e1;

  always_comb begin
    merged_par = par_mem[addr];
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) merged_par[i] = byte_par(data[8*i +: 8]);
    end
    rd_par = wfirst ? merged_par : par_mem[addr];
    rd_err = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      rd_err = rd_err | (byte_par(rd_word[8*i +: 8]) ^ rd_par[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)  par_mem[fill_addr] <= '0;
    else if (wr)  par_mem[addr]      <= merged_par;
  end

  // The flag follows its read down the same pipeline and holds until the next valid.
  always_ff @(posedge clk) begin
    if (rst)        e1 <= 1'b0;
    else if (rd_ok) e1 <= rd_err;
  end

  if (RD_LATENCY == 2) begin : g_perr2
    logic e2;
    always_ff @(posedge clk) begin
      if (rst)     e2 <= 1'b0;
      else if (v1) e2 <= e1;
    end
    assign perr = e2;
  end else begin : g_perr1
    assign perr = e1;
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: four elaborations (READ_FIRST, WRITE_FIRST, NO_CHANGE at
// latency 1, READ_FIRST at latency 2) share one stimulus stream and one array model.
module tb_sp_ram_param;

  localparam int unsigned MODE [4] = '{0, 1, 2, 0};
  localparam int unsigned LAT  [4] = '{1, 1, 1, 2};

  logic        clk = 1'b0;
  logic        rst, we, re;
  logic [15:0] data;
  logic [5:0]  addr;
  logic [1:0]  be;
  logic [15:0] qo [4];
  logic        qv [4], bz [4], pe [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sp_ram_param #(.DATA_W(16), .ADDR_W(6), .RD_LATENCY(LAT[gi]), .RDW_MODE(MODE[gi])) u_dut (
      .clk(clk), .rst(rst), .data(data), .addr(addr), .we(we), .be(be), .re(re),
      .q(qo[gi]), .q_valid(qv[gi]), .busy(bz[gi]), .perr(pe[gi])
    );
  end

  // Model: word contents, per-lane corrupted-parity marks, fill progress, expected outputs.
  logic [15:0] mm [64];
  logic [1:0]  bad [64];
  int          fillcnt = 0;
  logic [15:0] eq [4], s1d [4];
  logic        ev [4], ep [4], s1v [4], s1e [4];
  int          vectors = 0;
  int          errs = 0;

  task automatic chk(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s[u%0d] observed=%h expected=%h at %0t", tag, inst, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic rs, input logic w, input logic r, input logic [5:0] a,
                     input logic [15:0] d, input logic [1:0] b);
    logic        acc, rv, wf, rerr;
    logic [15:0] old, nw, rdv;
    rst = rs; we = w; re = r; addr = a; data = d; be = b;
    @(posedge clk);
    acc = !(rs || fillcnt < 64);
    old = mm[a];
    nw  = old;
    if (b[0]) nw[7:0]  = d[7:0];
    if (b[1]) nw[15:8] = d[15:8];
    for (int i = 0; i < 4; i++) begin
      rv   = acc && r && !(MODE[i] == 2 && w);
      wf   = acc && w && MODE[i] == 1;
      rdv  = wf ? nw : old;
      rerr = |(bad[a] & (wf ? ~b : 2'b11));
      if (rs) begin
        ev[i] = 0; eq[i] = '0; ep[i] = 0; s1v[i] = 0; s1d[i] = '0; s1e[i] = 0;
      end else if (LAT[i] == 1) begin
        ev[i] = rv;
        if (rv) begin eq[i] = rdv; ep[i] = rerr; end
      end else begin
        ev[i] = s1v[i];
        if (s1v[i]) begin eq[i] = s1d[i]; ep[i] = s1e[i]; end
        s1v[i] = rv;
        if (rv) begin s1d[i] = rdv; s1e[i] = rerr; end
      end
    end
    if (rs) fillcnt = 0;
    else if (fillcnt < 64) begin
      mm[fillcnt] = '0; bad[fillcnt] = '0; fillcnt++;
    end else if (w) begin
      mm[a] = nw; bad[a] = bad[a] & ~b;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("busy", i, {15'd0, bz[i]}, {15'd0, rs || fillcnt < 64});
      chk("q_valid", i, {15'd0, qv[i]}, {15'd0, ev[i]});
      chk("q", i, qo[i], eq[i]);
      chk("perr", i, {15'd0, pe[i]}, {15'd0, ep[i]});
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 6'd0, 16'h0, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bad[i] = '0;
    for (int i = 0; i < 4; i++) begin
      eq[i] = '0; s1d[i] = '0; ev[i] = 0; ep[i] = 0; s1v[i] = 0; s1e[i] = 0;
    end

    // Reset, then the 64-cycle fill with a read at fill cycle 10 that must be dropped.
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 6'd0, 16'h0, 2'b00);
    for (int k = 0; k < 64; k++) cyc(0, 0, k == 10, 6'd3, 16'h0, 2'b00);
    for (int k = 0; k < 64; k++) cyc(0, 0, 1, 6'(k), 16'h0, 2'b00);
    idle(2);

    // Byte-lane writes.
    cyc(0, 1, 0, 6'd5, 16'hAABB, 2'b11);
    cyc(0, 1, 0, 6'd5, 16'h1122, 2'b01);
    cyc(0, 0, 1, 6'd5, 16'h0, 2'b00);
    chk("lane_merge", 0, qo[0], 16'hAA22);
    idle(2);
    chk("lane_merge_lat2", 3, qo[3], 16'hAA22);

    // Read-during-write on addr 9.
    cyc(0, 1, 0, 6'd9, 16'h1234, 2'b11);
    cyc(0, 1, 1, 6'd9, 16'hBEEF, 2'b11);
    chk("rdw_read_first", 0, qo[0], 16'h1234);
    chk("rdw_write_first", 1, qo[1], 16'hBEEF);
    chk("rdw_no_change_v", 2, {15'd0, qv[2]}, 16'h0000);
    idle(2);

    // Back-to-back reads of 1,2,3 for the latency-2 instance.
    for (int k = 1; k <= 3; k++) cyc(0, 1, 0, 6'(k), 16'(16'h0100 * k + k), 2'b11);
    for (int k = 1; k <= 3; k++) cyc(0, 0, 1, 6'(k), 16'h0, 2'b00);
    idle(3);

    // Reset at fill cycle 20; busy must span a fresh full fill.
    cyc(1, 0, 0, 6'd0, 16'h0, 2'b00);
    for (int k = 0; k < 20; k++) cyc(0, 1, 1, 6'(k), 16'hFFFF, 2'b11);
    cyc(1, 0, 1, 6'd0, 16'h0, 2'b00);
    for (int k = 0; k < 64; k++) cyc(0, 1, 1, 6'($urandom_range(0, 63)), 16'($urandom), 2'b11);
    idle(2);

    // Randomized traffic on a small address window to force reuse.
    for (int k = 0; k < 400; k++)
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)),
          16'($urandom), 2'($urandom_range(0, 3)));
    idle(3);

`ifdef SP_RAM_PARITY_EN
    cyc(0, 1, 0, 6'd7, 16'h5A3C, 2'b11);
    cyc(0, 1, 0, 6'd8, 16'h0F01, 2'b11);
    g_dut[0].u_dut.par_mem[7][0] = ~g_dut[0].u_dut.par_mem[7][0];
    g_dut[1].u_dut.par_mem[7][0] = ~g_dut[1].u_dut.par_mem[7][0];
    g_dut[2].u_dut.par_mem[7][0] = ~g_dut[2].u_dut.par_mem[7][0];
    g_dut[3].u_dut.par_mem[7][0] = ~g_dut[3].u_dut.par_mem[7][0];
    bad[7] = 2'b01;
    cyc(0, 0, 1, 6'd7, 16'h0, 2'b00);
    chk("perr_set", 0, {15'd0, pe[0]}, 16'h0001);
    idle(2);
    cyc(0, 0, 1, 6'd8, 16'h0, 2'b00);
    chk("perr_clear", 0, {15'd0, pe[0]}, 16'h0000);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
